param_proc_core: RTL and testbench

PARAM_PROC_CORE -- requirements
Module: param_proc_core

---
 rtl/proc_pkg.sv | 68 ++++++
 rtl/proc_reg_file.sv | 32 +++
 rtl/param_proc_core.sv | 180 ++++++++++++++++++
 tb/tb_param_proc_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared encodings for the parameterised processor core: FSM states,
// opcodes, condition codes and the small decode helpers used by the top.
package proc_pkg;

    localparam int NUM_REGS = 8;
    localparam int REG_AW   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    // Undefined opcodes (1001, 1010, 1111) decode as NOP.
    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_LSL1 = 4'b0101,
        OP_LSR1 = 4'b0110,
        OP_MOVI = 4'b0111,
        OP_HLT  = 4'b1000,
        OP_CMP  = 4'b1011,
        OP_B    = 4'b1100,
        OP_LDR  = 4'b1101,
        OP_STR  = 4'b1110
    } opcode_t;

    typedef enum logic [1:0] {
        CC_AL = 2'b00,
        CC_EQ = 2'b01,
        CC_GE = 2'b10,
        CC_LT = 2'b11
    } cond_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    function automatic logic cond_pass(input logic [1:0] cc, input flags_t f);
        case (cc)
            CC_AL:   return 1'b1;
            CC_EQ:   return f.z;
            CC_GE:   return f.n == f.v;
            default: return f.n != f.v;
        endcase
    endfunction

    // Opcodes that go through EXEC (includes MOVI and CMP).
    function automatic logic is_exec_op(input logic [3:0] op);
        return (op <= OP_MOVI) || (op == OP_CMP);
    endfunction

    // Opcodes whose EXEC cycle updates the flag register.
    function automatic logic is_flag_op(input logic [3:0] op);
        return (op <= OP_LSR1) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/proc_reg_file.sv
// 8-entry register file: two combinational read ports, one synchronous
// write port, asynchronous clear.
module proc_reg_file
    import proc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule

// File: rtl/param_proc_core.sv
// Multi-cycle 16-bit-instruction processor core: FETCH/DECODE/EXEC/MEM/WB
// sequencing, inline ALU with NZCV flags, and a req/ack data-memory port.
module param_proc_core
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8,
    parameter int MEM_AW = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       instr_data,
    input  logic              instr_vld,
    output logic              instr_req,
    output logic [PC_W-1:0]   pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              negative,
    output logic              overflow,
    output logic              carry,
    output logic              halted
);

    localparam int MSB = DATA_W - 1;

    state_t            state, state_nxt;
    logic [15:0]       ir;
    logic [DATA_W-1:0] a_val, b_val, wb_data;
    logic [DATA_W-1:0] rf_a, rf_b;
    flags_t            flags;

    logic [1:0]        f_cond;
    logic [3:0]        f_op;
    logic [REG_AW-1:0] f_dest, f_op1, f_op2, rb_sel;
    logic [6:0]        f_imm;
    logic              cc_ok;

    assign f_cond = ir[15:14];
    assign f_op   = ir[13:10];
    assign f_dest = ir[9:7];
    assign f_op1  = ir[6:4];
    assign f_op2  = ir[3:1];
    assign f_imm  = ir[6:0];
    assign cc_ok  = cond_pass(f_cond, flags);
    // STR sources its store data from the dest field.
    assign rb_sel = (f_op == OP_STR) ? f_dest : f_op2;

    proc_reg_file #(.DATA_W(DATA_W)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (f_op1),
        .ra_data (rf_a),
        .rb_addr (rb_sel),
        .rb_data (rf_b),
        .we      (state == ST_WB),
        .waddr   (f_dest),
        .wdata   (wb_data)
    );

    // ---------------- ALU ----------------
    logic [DATA_W-1:0] alu_r;
    logic              alu_c, alu_v;
    logic [DATA_W:0]   sum, diff;

    assign sum  = {1'b0, a_val} + {1'b0, b_val};
    assign diff = {1'b0, a_val} - {1'b0, b_val};

    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (f_op)
            OP_ADD: begin
                alu_r = sum[MSB:0];
                alu_c = sum[DATA_W];
                alu_v = (a_val[MSB] == b_val[MSB]) && (alu_r[MSB] != a_val[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_r = diff[MSB:0];
                alu_c = ~diff[DATA_W];
                alu_v = (a_val[MSB] != b_val[MSB]) && (alu_r[MSB] != a_val[MSB]);
            end
            OP_AND:  alu_r = a_val & b_val;
            OP_OR:   alu_r = a_val | b_val;
            OP_XOR:  alu_r = a_val ^ b_val;
            OP_LSL1: begin
                alu_r = {a_val[MSB-1:0], 1'b0};
                alu_c = a_val[MSB];
            end
            OP_LSR1: begin
                alu_r = {1'b0, a_val[MSB:1]};
                alu_c = a_val[0];
            end
            OP_MOVI: alu_r = DATA_W'(f_imm);
            default: ;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH:  if (instr_vld) state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (!cc_ok)                               state_nxt = ST_FETCH;
                else if (f_op == OP_HLT)                  state_nxt = ST_HALT;
                else if (f_op == OP_LDR || f_op == OP_STR) state_nxt = ST_MEM;
                else if (is_exec_op(f_op))                state_nxt = ST_EXEC;
                else                                      state_nxt = ST_FETCH;
            end
            ST_EXEC:   state_nxt = (f_op == OP_CMP) ? ST_FETCH : ST_WB;
            ST_MEM:    if (mem_ack) state_nxt = (f_op == OP_STR) ? ST_FETCH : ST_WB;
            ST_WB:     state_nxt = ST_FETCH;
            ST_HALT:   if (start) state_nxt = ST_FETCH;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_req = (state == ST_FETCH);
        mem_req   = (state == ST_MEM);
        mem_we    = (state == ST_MEM) && (f_op == OP_STR);
        halted    = (state == ST_HALT);
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= '0;
            pc      <= '0;
            a_val   <= '0;
            b_val   <= '0;
            wb_data <= '0;
            flags   <= '0;
            result  <= '0;
        end else begin
            case (state)
                ST_FETCH: if (instr_vld) ir <= instr_data;
                ST_DECODE: begin
                    a_val <= rf_a;
                    b_val <= rf_b;
                    pc    <= (cc_ok && f_op == OP_B) ? PC_W'(f_imm) : pc + PC_W'(1);
                end
                ST_EXEC: begin
                    wb_data <= alu_r;
                    if (is_flag_op(f_op)) begin
                        flags.z <= (alu_r == '0);
                        flags.n <= alu_r[MSB];
                        flags.c <= alu_c;
                        flags.v <= alu_v;
                    end
                end
                ST_MEM:  if (mem_ack && f_op == OP_LDR) wb_data <= mem_rdata;
                ST_WB:   result <= wb_data;
                default: ;
            endcase
        end
    end

    assign mem_addr  = a_val[MEM_AW-1:0];
    assign mem_wdata = b_val;
    assign zero      = flags.z;
    assign negative  = flags.n;
    assign carry     = flags.c;
    assign overflow  = flags.v;

endmodule

// File: tb/tb_param_proc_core.sv
// Directed bench for param_proc_core (PC_W=4 so pc wrap is reachable):
// hand-computed expectations checked with immediate assertions.
module tb_param_proc_core;

    localparam int DATA_W = 16;
    localparam int PC_W   = 4;
    localparam int MEM_AW = 7;

    logic              clk = 1'b0;
    logic              rst_n, start, instr_vld, instr_req;
    logic [15:0]       instr_data;
    logic [PC_W-1:0]   pc;
    logic              mem_req, mem_we, mem_ack;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata, result;
    logic              zero, negative, overflow, carry, halted;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [DATA_W-1:0] mem_model [0:(1<<MEM_AW)-1];

    param_proc_core #(.DATA_W(DATA_W), .PC_W(PC_W), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .instr_data(instr_data), .instr_vld(instr_vld),
        .instr_req(instr_req), .pc(pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .result(result), .zero(zero), .negative(negative),
        .overflow(overflow), .carry(carry), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // flags compared as {Z,N,C,V}
    task automatic chk_flags(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, zero, negative, carry, overflow}, {28'd0, exp});
    endtask

    function automatic logic [15:0] rrr(input logic [1:0] c, input logic [3:0] op,
                                        input logic [2:0] d, input logic [2:0] a,
                                        input logic [2:0] b);
        return {c, op, d, a, b, 1'b0};
    endfunction

    function automatic logic [15:0] ri(input logic [1:0] c, input logic [3:0] op,
                                       input logic [2:0] d, input logic [6:0] imm);
        return {c, op, d, imm};
    endfunction

    task automatic issue(input logic [15:0] w);
        int n = 0;
        while (!instr_req && n < 50) begin @(posedge clk); #1; n++; end
        chk("fetch_ready", {31'd0, instr_req}, 32'd1);
        instr_data = w;
        instr_vld  = 1'b1;
        @(posedge clk); #1;
        instr_vld  = 1'b0;
    endtask

    // Returns instr_vld-cycle to next instr_req-cycle latency.
    task automatic wait_fetch(output int l);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!instr_req && n < 50);
        chk("fetch_return", {31'd0, instr_req}, 32'd1);
        l = n + 1;
    endtask

    task automatic run(input logic [15:0] w);
        int l;
        issue(w);
        wait_fetch(l);
    endtask

    task automatic wait_mem();
        int n = 0;
        while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
        chk("mem_req_seen", {31'd0, mem_req}, 32'd1);
    endtask

    // Hold off ack until the k-th MEM cycle; mem_req must stay up meanwhile.
    task automatic mem_ack_at(input int k);
        for (int i = 1; i <= k; i++) begin
            chk("mem_req_hold", {31'd0, mem_req}, 32'd1);
            if (i == k) begin
                if (mem_we) mem_model[mem_addr] = mem_wdata;
                else        mem_rdata = mem_model[mem_addr];
                mem_ack = 1'b1;
            end
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        chk("mem_req_drop", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; instr_vld = 1'b0; instr_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk); #1;

        // reset state
        chk("rst_pc", {28'd0, pc}, 32'd0);
        chk("rst_instr_req", {31'd0, instr_req}, 32'd0);
        chk("rst_mem", {30'd0, mem_req, mem_we}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk_flags("rst_flags", 4'b0000);

        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("no_fetch_before_start", {31'd0, instr_req}, 32'd0);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        chk("fetch_after_start", {31'd0, instr_req}, 32'd1);

        // MOVI r1,5; MOVI r2,3; SUB r3,r1,r2
        run(ri(2'b00, 4'b0111, 3'd1, 7'd5));
        run(ri(2'b00, 4'b0111, 3'd2, 7'd3));
        run(rrr(2'b00, 4'b0001, 3'd3, 3'd1, 3'd2));
        chk("sub_result", {16'd0, result}, 32'd2);
        chk_flags("sub_flags", 4'b0010);
        chk("sub_pc", {28'd0, pc}, 32'd3);

        // r4 = 1 << 15 via 15 x LSL1
        run(ri(2'b00, 4'b0111, 3'd4, 7'd1));
        for (int i = 0; i < 15; i++) run(rrr(2'b00, 4'b0101, 3'd4, 3'd4, 3'd0));
        chk("lsl_result", {16'd0, result}, 32'h8000);
        chk_flags("lsl_flags", 4'b0100);
        run(rrr(2'b00, 4'b0101, 3'd7, 3'd4, 3'd0));
        chk("lsl_out_result", {16'd0, result}, 32'h0000);
        chk_flags("lsl_out_flags", 4'b1010);
        run(ri(2'b00, 4'b0111, 3'd5, 7'd1));
        run(rrr(2'b00, 4'b0001, 3'd4, 3'd4, 3'd5));
        chk("sub_ovf_result", {16'd0, result}, 32'h7FFF);
        chk_flags("sub_ovf_flags", 4'b0011);
        run(rrr(2'b00, 4'b0000, 3'd6, 3'd4, 3'd5));
        chk("add_ovf_result", {16'd0, result}, 32'h8000);
        chk_flags("add_ovf_flags", 4'b0101);
        chk("pc_wrap_mid", {28'd0, pc}, 32'd7);

        // CMP r1,r1 then conditional MOVIs
        run(rrr(2'b00, 4'b1011, 3'd0, 3'd1, 3'd1));
        chk_flags("cmp_flags", 4'b1010);
        chk("cmp_no_write", {16'd0, result}, 32'h8000);
        run(ri(2'b01, 4'b0111, 3'd4, 7'd9));
        chk("cond_eq_taken", {16'd0, result}, 32'd9);
        issue(ri(2'b11, 4'b0111, 3'd5, 7'd7));
        wait_fetch(lat);
        chk("cond_lt_latency", lat, 32'd2);
        chk("cond_lt_skipped", {16'd0, result}, 32'd9);
        chk("cond_pc", {28'd0, pc}, 32'd10);

        // MOVI r2,4; STR r1->[r2] with ack on 3rd MEM cycle
        run(ri(2'b00, 4'b0111, 3'd2, 7'd4));
        issue(rrr(2'b00, 4'b1110, 3'd1, 3'd2, 3'd0));
        wait_mem();
        chk("str_we", {31'd0, mem_we}, 32'd1);
        chk("str_addr", {25'd0, mem_addr}, 32'd4);
        chk("str_wdata", {16'd0, mem_wdata}, 32'd5);
        mem_ack_at(3);
        chk("str_to_fetch", {31'd0, instr_req}, 32'd1);
        chk("str_no_write", {16'd0, result}, 32'd4);

        // stray ack outside MEM is ignored
        mem_ack = 1'b1; @(posedge clk); #1; mem_ack = 1'b0;
        chk("stray_ack", {30'd0, instr_req, mem_req}, 32'b10);

        // LDR r6<-[r2]
        issue(rrr(2'b00, 4'b1101, 3'd6, 3'd2, 3'd0));
        wait_mem();
        chk("ldr_we", {31'd0, mem_we}, 32'd0);
        mem_ack_at(1);
        wait_fetch(lat);
        chk("ldr_result", {16'd0, result}, 32'd5);
        chk_flags("ldr_flags_kept", 4'b1010);

        // STR r5 shows r5 untouched by the skipped MOVI
        issue(rrr(2'b00, 4'b1110, 3'd5, 3'd2, 3'd0));
        wait_mem();
        chk("r5_unchanged", {16'd0, mem_wdata}, 32'd1);
        mem_ack_at(1);
        chk("pc_after_str", {28'd0, pc}, 32'd14);

        // B 15, NOP wraps pc, HLT
        issue(ri(2'b00, 4'b1100, 3'd0, 7'd15));
        wait_fetch(lat);
        chk("b_latency", lat, 32'd2);
        chk("b_pc", {28'd0, pc}, 32'd15);
        run(16'b00_1111_0000000000);
        chk("nop_pc_wrap", {28'd0, pc}, 32'd0);
        issue(16'b00_1000_0000000000);
        @(posedge clk); #1;
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        chk("hlt_pc", {28'd0, pc}, 32'd1);
        repeat (4) @(posedge clk); #1;
        chk("hlt_no_fetch", {31'd0, instr_req}, 32'd0);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        chk("hlt_restart", {30'd0, instr_req, halted}, 32'b10);

        // reset in the middle of a memory transaction
        issue(rrr(2'b00, 4'b1101, 3'd6, 3'd2, 3'd0));
        wait_mem();
        rst_n = 1'b0; #1;
        chk("rst_mid_mem_req", {30'd0, mem_req, mem_we}, 32'd0);
        chk("rst_mid_pc", {28'd0, pc}, 32'd0);
        chk("rst_mid_result", {16'd0, result}, 32'd0);
        chk_flags("rst_mid_flags", 4'b0000);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rst_mid_idle", {31'd0, instr_req}, 32'd0);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;

        // registers cleared: STR r1->[r2] gives addr 0, data 0
        issue(rrr(2'b00, 4'b1110, 3'd1, 3'd2, 3'd0));
        wait_mem();
        chk("rst_regs_addr", {25'd0, mem_addr}, 32'd0);
        chk("rst_regs_data", {16'd0, mem_wdata}, 32'd0);
        mem_ack_at(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
